// File: rtl/mmio_bridge_if.sv
// mmio_bridge_if: CPU request/response and device-bank strobe bundle around the bridge
interface mmio_bridge_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [15:0] err_count;
  logic        mmio_read;
  logic        mmio_write;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_write_data;
  logic        mmio_done;
  logic [31:0] mmio_read_data;
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, mmio_done, mmio_read_data,
    output req_ready, busy, resp_valid, resp_rdata, resp_error, err_count,
           mmio_read, mmio_write, mmio_addr, mmio_write_data
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, mmio_done, mmio_read_data,
    input  req_ready, busy, resp_valid, resp_rdata, resp_error, err_count,
           mmio_read, mmio_write, mmio_addr, mmio_write_data
  );
endinterface

// File: rtl/mmio_bridge.sv
// mmio_bridge: single-word CPU load/store to MMIO device bank with timeout and error count
module mmio_bridge #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input logic           sys_clk,
  input logic           rst,
  mmio_bridge_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t      state, state_nxt;
  logic        wr_q, err_q;
  logic [15:0] cnt, err_cnt;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        aligned, timeout;
  assign aligned = bus.req_addr[1:0] == 2'b00;
  assign timeout = cnt == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge sys_clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  always_comb begin
    state_nxt = (state == IDLE) ? (bus.req_valid ? (aligned ? BUSY : RESP) : IDLE) :
                (state == BUSY) ? ((bus.mmio_done || timeout) ? RESP : BUSY) : IDLE;
  end
  // strobes come only from registers so the bank never sees a glitch
  always_comb begin
    bus.req_ready       = state == IDLE;
    bus.busy            = state != IDLE;
    bus.resp_valid      = state == RESP;
    bus.mmio_read       = state == BUSY && !wr_q;
    bus.mmio_write      = state == BUSY && wr_q;
    bus.mmio_addr       = addr_q;
    bus.mmio_write_data = wdata_q;
    bus.resp_rdata      = rdata_q;
    bus.resp_error      = err_q;
    bus.err_count       = err_cnt;
  end
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt     <= '0;
      err_cnt <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        if (aligned) begin
          addr_q  <= bus.req_addr;
          wdata_q <= bus.req_wdata;
          wr_q    <= bus.req_write;
          cnt     <= '0;
        end else begin
          err_q   <= 1'b1;
          rdata_q <= ERR_RDATA;
        end
      end
      // completion beats a coincident timeout
      if (state == BUSY) begin
        if (bus.mmio_done) begin
          rdata_q <= wr_q ? 32'd0 : bus.mmio_read_data;
          err_q   <= 1'b0;
        end else if (timeout) begin
          err_q   <= 1'b1;
          rdata_q <= ERR_RDATA;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end
      if (state == RESP && err_q && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: randomized scoreboard bench with a memory-model device bank
module tb_mmio_bridge;
  localparam int          TO   = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
  typedef struct {
    logic        wr;
    logic [31:0] addr, wdata, rdata;
    logic        err;
    int          lat, strobes, acc;
  } exp_t;
  logic sys_clk = 1'b0;
  logic rst = 1'b1;
  mmio_bridge_if bus();
  mmio_bridge #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERRD)) dut (
    .sys_clk(sys_clk), .rst(rst), .bus(bus.master)
  );
  always #5 sys_clk = ~sys_clk;
  exp_t        q[$];
  exp_t        m_e;
  int          checks = 0, fails = 0, cyc = 0, model_errs = 0, bank_k = 0, scnt = 0, scount = 0;
  bit   [31:0] bank_mem [256];
  logic [31:0] model_mem [logic [31:0]];
  logic        noise = 1'b0;
  logic        strobe;
  assign strobe             = bus.mmio_read | bus.mmio_write;
  assign bus.mmio_done      = strobe ? (bank_k != 0 && scnt == bank_k - 1) : noise;
  assign bus.mmio_read_data = bus.mmio_done ? bank_mem[bus.mmio_addr[9:2]] : 32'hBAD0_BAD0;
  always @(posedge sys_clk) begin
    cyc   <= cyc + 1;
    scnt  <= strobe ? scnt + 1 : 0;
    if (bus.mmio_done && bus.mmio_write) bank_mem[bus.mmio_addr[9:2]] <= bus.mmio_write_data;
  end
  always @(negedge sys_clk) noise <= 1'($urandom % 2);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic flag(input string name);
    checks++;
    fails++;
    $display("FAIL %s at t=%0t", name, $time);
  endtask
  always @(negedge sys_clk) begin
    if (rst) scount = 0;
    else begin
      if (bus.mmio_read && bus.mmio_write) flag("both_strobes");
      if (q.size() == 0) scount = 0;
      if (strobe) begin
        scount++;
        if (q.size() == 0) flag("strobe_without_request");
        else begin
          chk("strobe_addr", bus.mmio_addr, q[0].addr);
          chk("strobe_wdata", bus.mmio_write_data, q[0].wdata);
          chk("strobe_dir", bus.mmio_write, q[0].wr);
        end
      end
      if (bus.resp_valid) begin
        if (q.size() == 0) flag("unexpected_resp");
        else begin
          m_e = q.pop_front();
          chk("resp_rdata", bus.resp_rdata, m_e.rdata);
          chk("resp_error", bus.resp_error, m_e.err);
          chk("resp_latency", 32'(cyc - m_e.acc), 32'(m_e.lat));
          chk("strobe_cycles", 32'(scount), 32'(m_e.strobes));
          chk("err_count", {16'd0, bus.err_count}, 32'(model_errs));
          if (m_e.err && model_errs < 32'hFFFF) model_errs++;
          scount = 0;
        end
      end
    end
  end
  task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata, input int k);
    exp_t e;
    int   w;
    w = 0;
    while (bus.req_ready !== 1'b1) begin
      if (++w > 100) begin
        flag("ready_wait_expired");
        return;
      end
      @(negedge sys_clk);
    end
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bank_k        = k;
    @(posedge sys_clk);
    #1;
    e.wr = wr; e.addr = addr; e.wdata = wdata; e.acc = cyc;
    if (addr[1:0] != 2'b00) begin
      e.err = 1'b1; e.rdata = ERRD; e.lat = 0; e.strobes = 0;
    end else if (k != 0 && k <= TO) begin
      e.err = 1'b0; e.lat = k; e.strobes = k;
      e.rdata = wr ? 32'd0 : (model_mem.exists(addr) ? model_mem[addr] : 32'd0);
      if (wr) model_mem[addr] = wdata;
    end else begin
      e.err = 1'b1; e.rdata = ERRD; e.lat = TO; e.strobes = TO;
    end
    q.push_back(e);
  endtask
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata, input int k);
    int w;
    drive_req(wr, addr, wdata, k);
    w = 0;
    forever begin
      @(negedge sys_clk);
      if (bus.req_ready === 1'b1) break;
      bus.req_valid = 1'($urandom % 2);
      bus.req_write = 1'($urandom % 2);
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      if (++w > 50) begin
        flag("busy_too_long");
        break;
      end
    end
    bus.req_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int w;
    logic [31:0] a;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    #1;
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_mmio_read", bus.mmio_read, 1'b0);
    chk("rst_mmio_write", bus.mmio_write, 1'b0);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_resp_error", bus.resp_error, 1'b0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_err_count", {16'd0, bus.err_count}, 32'd0);
    chk("rst_mmio_addr", bus.mmio_addr, 32'd0);
    chk("rst_mmio_wdata", bus.mmio_write_data, 32'd0);
    @(negedge sys_clk);
    #1 rst = 1'b0;
    @(negedge sys_clk);
    issue(1'b1, 32'hFFFF_0000, 32'h00A5_5A00, 2);
    issue(1'b0, 32'hFFFF_0000, 32'h0,         1);
    issue(1'b1, 32'hFFFF_0080, 32'h1234_5678, 3);
    issue(1'b0, 32'hFFFF_0080, 32'h0,         5);
    issue(1'b0, 32'hFFFF_0300, 32'h0,         0);
    issue(1'b1, 32'hFFFF_0082, 32'hCAFE_F00D, 1);
    issue(1'b0, 32'hFFFF_0000, 32'h0,         TO);
    issue(1'b1, 32'hFFFF_0004, 32'h0BAD_0001, TO + 1);
    drive_req(1'b0, 32'hFFFF_0040, 32'h0, 0);
    bus.req_valid = 1'b0;
    repeat (3) @(posedge sys_clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_mmio_read", bus.mmio_read, 1'b0);
    chk("midrst_mmio_write", bus.mmio_write, 1'b0);
    chk("midrst_req_ready", bus.req_ready, 1'b1);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_resp_valid", bus.resp_valid, 1'b0);
    chk("midrst_err_count", {16'd0, bus.err_count}, 32'd0);
    q.delete();
    model_errs = 0;
    @(negedge sys_clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge sys_clk);
    for (int i = 0; i < 300; i++) begin
      a = 32'hFFFF_0000 + 32'($urandom % 64) * 4;
      if ($urandom % 8 == 0) a[1:0] = 2'($urandom_range(1, 3));
      issue(1'($urandom % 2), a, $urandom, int'($urandom_range(0, TO + 2)));
      if ($urandom % 4 == 0) repeat ($urandom_range(1, 3)) @(negedge sys_clk);
    end
    force dut.err_cnt = 16'hFFF0;
    #1 release dut.err_cnt;
    model_errs = 32'hFFF0;
    @(negedge sys_clk);
    for (int i = 0; i < 20; i++) issue(1'($urandom % 2), 32'hFFFF_0001 + 32'(i) * 4, $urandom, 1);
    w = 0;
    while (q.size() != 0 && w < 50) begin
      @(negedge sys_clk);
      w++;
    end
    if (q.size() != 0) flag("drain_expired");
    repeat (2) @(negedge sys_clk);
    chk("err_count_saturated", {16'd0, bus.err_count}, 32'h0000_FFFF);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
